mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: consecutive data grants allowed while a fetch waits before fetch is forced.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_req  input  1  fetch request; held stable until i_gnt.
REQ-005 i_addr  input  32  fetch address; bits [1:0] ignored.
REQ-006 i_gnt  output  1  one-cycle pulse: fetch request accepted.
REQ-007 i_rvalid  output  1  one-cycle pulse: fetch data valid on rsp_rdata.
REQ-008 d_req  input  1  data request; held stable until d_gnt.
REQ-009 d_we  input  1  1 = store, 0 = load.
REQ-010 d_mode  input  MEMORY_MODE_WIDTH  access size, encoded with the shared BYTE/HALFWORD/WORD/NOP memory-mode macros.
REQ-011 d_addr  input  32  data byte address.
REQ-012 d_wdata  input  32  store data, right-aligned.
REQ-013 d_gnt  output  1  one-cycle pulse: data request accepted.
REQ-014 d_rvalid  output  1  one-cycle pulse: load data valid or store complete.
REQ-015 d_err  output  1  one-cycle pulse: misaligned or NOP-mode data request, no memory access.
REQ-016 rsp_rdata  output  32  raw memory word, pass-through of mem_rdata.
REQ-017 mem_req  output  1  request to the single-port memory, registered.
REQ-018 mem_we  output  1  memory write enable, registered.
REQ-019 mem_addr  output  32  word address {addr[31:2],2'b00}, registered.
REQ-020 mem_be  output  4  byte enables, registered.
REQ-021 mem_wdata  output  32  lane-replicated write data, registered.
REQ-022 mem_gnt  input  1  memory accepted mem_req this cycle.
REQ-023 mem_rvalid  input  1  memory response, at least 1 cycle after mem_gnt.
REQ-024 mem_rdata  input  32  memory read word, valid with mem_rvalid.

Function
REQ-025 The FSM SHALL have the states IDLE, ISSUE, WAIT_RSP and ERR, with at most one outstanding transaction.
REQ-026 In IDLE with any request, the block SHALL grant the winner combinationally, capture its fields into the mem_* registers and move to ISSUE next cycle.
REQ-027 Priority SHALL go to data unless i_req=1, d_req=1 and streak==STARVE_LIMIT, in which case fetch wins.
REQ-028 streak SHALL increment, saturating, on each data grant made while i_req=1, and SHALL clear on each fetch grant.
REQ-029 A data request that wins with half-word mode and addr[0]=1, word mode and addr[1:0]!=0, or NOP mode SHALL get d_gnt, then ERR for one cycle with d_err=1, then IDLE, with no mem_req.
REQ-030 mem_req SHALL be 1 exactly in ISSUE, and ISSUE SHALL move to WAIT_RSP on mem_gnt=1, holding otherwise.
REQ-031 In WAIT_RSP, mem_rvalid=1 SHALL pulse the owner's rvalid in the same cycle, with rsp_rdata=mem_rdata, and the FSM SHALL return to IDLE.
REQ-032 A new grant SHALL occur no earlier than the cycle after the response, giving one bubble cycle.
REQ-033 mem_rvalid outside WAIT_RSP SHALL be ignored.
REQ-034 Byte mode SHALL drive be=0001<<addr[1:0] and wdata={4{d_wdata[7:0]}}.
REQ-035 Half-word mode SHALL drive be=addr[1]?1100:0011 and wdata={2{d_wdata[15:0]}}.
REQ-036 Word mode and fetch SHALL drive be=1111, with fetch we=0.
REQ-037 i_gnt and d_gnt SHALL never be 1 in the same cycle.

Reset
REQ-038 rst_n=0 SHALL immediately force IDLE, streak=0, all mem_* registers and pulses to 0, and SHALL drop any in-flight transaction, with its late mem_rvalid ignored.

Verification
REQ-039 Fetch-only: i_req, addr 0x104, mem_gnt in ISSUE, mem_rvalid 2 cycles later with 0xDEADBEEF -> i_gnt in cycle 0, mem_addr 0x104, mem_be 1111, i_rvalid with rsp_rdata 0xDEADBEEF.
REQ-040 SB: addr 0x203, wdata 0xAB -> mem_addr 0x200, be 1000, mem_wdata 0xABABABAB, mem_we=1, d_rvalid on completion.
REQ-041 Misaligned: LH at 0x11 -> d_gnt, then d_err the next cycle, with mem_req never asserted.
REQ-042 Starvation: i_req and d_req held continuously, STARVE_LIMIT=3 -> grant order D,D,D,I,D,D,D,I.
REQ-043 Reset mid-operation: rst_n low in WAIT_RSP, then mem_rvalid after release -> no rvalid pulse, state IDLE.
REQ-044 mem_gnt held low for 5 cycles -> mem_req stays 1 with stable addr, be, we and wdata, with no further grants.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter in front of one single-port memory, one transaction in flight
//   fetch side : i_req, i_addr -> i_gnt, i_rvalid
//   data side  : d_req, d_we, d_mode, d_addr, d_wdata -> d_gnt, d_rvalid, d_err
//   response   : rsp_rdata (raw mem_rdata)
//   memory side: mem_req, mem_we, mem_addr, mem_be, mem_wdata (registered) <- mem_gnt, mem_rvalid, mem_rdata
`ifndef MEMORY_MODE_WIDTH
`define MEMORY_MODE_WIDTH 2
`endif
`ifndef BYTE
`define BYTE 2'd0
`endif
`ifndef HALFWORD
`define HALFWORD 2'd1
`endif
`ifndef WORD
`define WORD 2'd2
`endif
`ifndef NOP
`define NOP 2'd3
`endif
module mem_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_req,
  input  logic [31:0]                   i_addr,
  output logic                          i_gnt,
  output logic                          i_rvalid,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [`MEMORY_MODE_WIDTH-1:0] d_mode,
  input  logic [31:0]                   d_addr,
  input  logic [31:0]                   d_wdata,
  output logic                          d_gnt,
  output logic                          d_rvalid,
  output logic                          d_err,
  output logic [31:0]                   rsp_rdata,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [31:0]                   mem_addr,
  output logic [3:0]                    mem_be,
  output logic [31:0]                   mem_wdata,
  input  logic                          mem_gnt,
  input  logic                          mem_rvalid,
  input  logic [31:0]                   mem_rdata
);
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, ERR} state_t;
  state_t state, state_n;
  logic [SW-1:0] streak;
  logic owner_d;
  logic pick_i, d_mis, starved;
  logic [31:0] sel_addr, wdata_n;
  logic [3:0] be_n;
  // fetch only beats a pending data request once data has won STARVE_LIMIT times in a row
  assign starved  = streak == SW'(STARVE_LIMIT);
  assign pick_i   = i_req & (~d_req | starved);
  assign i_gnt    = state == IDLE & pick_i;
  assign d_gnt    = state == IDLE & d_req & ~pick_i;
  assign d_mis    = (d_mode == `HALFWORD & d_addr[0]) | (d_mode == `WORD & d_addr[1:0] != 2'b00) | d_mode == `NOP;
  assign d_err    = state == ERR;
  assign i_rvalid = state == WAIT_RSP & mem_rvalid & ~owner_d;
  assign d_rvalid = state == WAIT_RSP & mem_rvalid & owner_d;
  assign rsp_rdata = mem_rdata;
  always_comb begin
    sel_addr = i_gnt ? i_addr : d_addr;
    be_n     = i_gnt ? 4'b1111
             : d_mode == `BYTE ? 4'b0001 << d_addr[1:0]
             : d_mode == `HALFWORD ? (d_addr[1] ? 4'b1100 : 4'b0011)
             : 4'b1111;
    wdata_n  = i_gnt ? 32'h0
             : d_mode == `BYTE ? {4{d_wdata[7:0]}}
             : d_mode == `HALFWORD ? {2{d_wdata[15:0]}}
             : d_wdata;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = i_gnt ? ISSUE : d_gnt ? (d_mis ? ERR : ISSUE) : IDLE;
      ISSUE:    state_n = mem_gnt ? WAIT_RSP : ISSUE;
      WAIT_RSP: state_n = mem_rvalid ? IDLE : WAIT_RSP;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      streak    <= '0;
      owner_d   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      state   <= state_n;
      mem_req <= state_n == ISSUE;
      if (i_gnt) streak <= '0;
      else if (d_gnt & i_req & ~starved) streak <= streak + 1'b1;
      if (state == IDLE & state_n == ISSUE) begin
        owner_d   <= d_gnt;
        mem_we    <= d_gnt & d_we;
        mem_addr  <= {sel_addr[31:2], 2'b00};
        mem_be    <= be_n;
        mem_wdata <= wdata_n;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed-vector self-checking bench for mem_arbiter
`ifndef MEMORY_MODE_WIDTH
`define MEMORY_MODE_WIDTH 2
`endif
`ifndef BYTE
`define BYTE 2'd0
`endif
`ifndef HALFWORD
`define HALFWORD 2'd1
`endif
`ifndef WORD
`define WORD 2'd2
`endif
`ifndef NOP
`define NOP 2'd3
`endif
module tb_mem_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [`MEMORY_MODE_WIDTH-1:0] d_mode = `WORD;
  logic mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic i_gnt, i_rvalid, d_gnt, d_rvalid, d_err, mem_req, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  int n_chk = 0, n_fail = 0;
  string order = "DDDIDDDI";
  mem_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .d_req(d_req), .d_we(d_we), .d_mode(d_mode), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .rsp_rdata(rsp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic serve(input bit data, input logic [31:0] rd);
    mem_gnt = 1'b1;
    tick;
    mem_gnt = 1'b0;
    #1 chk("req_drop", mem_req, 0);
    tick;
    mem_rvalid = 1'b1;
    mem_rdata = rd;
    #1 chk("i_rvalid", i_rvalid, !data);
    chk("d_rvalid", d_rvalid, data);
    chk("rsp_rdata", rsp_rdata, rd);
    tick;
    mem_rvalid = 1'b0;
    #1 chk("rvalid_off", {i_rvalid, d_rvalid}, 0);
  endtask
  initial begin
    #12;
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_pulses", {i_gnt, d_gnt, d_err, i_rvalid, d_rvalid}, 0);
    rst_n = 1'b1;
    tick;
    i_req = 1'b1;
    i_addr = 32'h104;
    #1 chk("f_gnt", {i_gnt, d_gnt}, 2'b10);
    tick;
    i_req = 1'b0;
    #1 chk("f_req", mem_req, 1);
    chk("f_addr", mem_addr, 32'h104);
    chk("f_be", mem_be, 4'hf);
    chk("f_we", mem_we, 0);
    serve(0, 32'hDEADBEEF);
    d_req = 1'b1; d_we = 1'b1; d_mode = `BYTE; d_addr = 32'h203; d_wdata = 32'hAB;
    #1 chk("sb_gnt", {i_gnt, d_gnt}, 2'b01);
    tick;
    d_req = 1'b0;
    #1 chk("sb_addr", mem_addr, 32'h200);
    chk("sb_be", mem_be, 4'b1000);
    chk("sb_wdata", mem_wdata, 32'hABABABAB);
    chk("sb_we", mem_we, 1);
    serve(1, 32'h0);
    d_req = 1'b1; d_we = 1'b0; d_mode = `HALFWORD; d_addr = 32'h11;
    #1 chk("lh_gnt", d_gnt, 1);
    tick;
    d_req = 1'b0;
    #1 chk("lh_err", d_err, 1);
    chk("lh_req", mem_req, 0);
    tick;
    chk("lh_err_off", d_err, 0);
    chk("lh_req_off", mem_req, 0);
    d_req = 1'b1; d_we = 1'b1; d_mode = `NOP; d_addr = 32'h40;
    #1 chk("nop_gnt", d_gnt, 1);
    tick;
    d_req = 1'b0;
    #1 chk("nop_err", {d_err, mem_req}, 2'b10);
    tick;
    d_req = 1'b1; d_we = 1'b1; d_mode = `HALFWORD; d_addr = 32'h22; d_wdata = 32'h12345678;
    #1 chk("sh_gnt", d_gnt, 1);
    tick;
    d_req = 1'b0;
    i_req = 1'b1;
    i_addr = 32'h300;
    for (int k = 0; k < 5; k++) begin
      chk("stall_req", mem_req, 1);
      chk("stall_addr", mem_addr, 32'h20);
      chk("stall_be", mem_be, 4'b1100);
      chk("stall_we", mem_we, 1);
      chk("stall_wdata", mem_wdata, 32'h56785678);
      chk("stall_gnt", {i_gnt, d_gnt}, 0);
      tick;
    end
    i_req = 1'b0;
    serve(1, 32'h0);
    i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_mode = `WORD; d_addr = 32'h400;
    for (int k = 0; k < 8; k++) begin
      bit is_i;
      is_i = order[k] == "I";
      #1 chk("order", {i_gnt, d_gnt}, is_i ? 2'b10 : 2'b01);
      tick;
      chk("order_addr", mem_addr, is_i ? 32'h300 : 32'h400);
      serve(!is_i, 32'h1000 + k);
    end
    i_req = 1'b0;
    d_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_mode = `WORD; d_addr = 32'h500;
    #1 chk("rs_gnt", d_gnt, 1);
    tick;
    d_req = 1'b0;
    mem_gnt = 1'b1;
    tick;
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1 chk("rs_clear", {mem_req, mem_we, mem_be}, 0);
    chk("rs_addr", mem_addr, 0);
    tick;
    rst_n = 1'b1;
    tick;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h55AA55AA;
    #1 chk("rs_late", {i_rvalid, d_rvalid}, 0);
    tick;
    mem_rvalid = 1'b0;
    i_req = 1'b1; i_addr = 32'h600;
    #1 chk("rs_idle", {i_gnt, d_gnt}, 2'b10);
    tick;
    i_req = 1'b0;
    serve(0, 32'hCAFEF00D);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
